// File: rtl/audio_pkg.sv
// Shared audio-path definitions for the I2S transmitter and receiver.
//   SAMPLE_W_DEF : default sample width per channel
//   rx_state_e   : receiver framing state (SYNC / LEFT / RIGHT)
package audio_pkg;

    localparam int SAMPLE_W_DEF = 16;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a third stage
// that yields a single-cycle rising-edge strobe.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   async_in   : asynchronous input level
//   level      : synchronised level (two flops deep)
//   rise       : one-cycle strobe on a synchronised 0->1 transition
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta_p0;
    logic sync_p1;
    logic dly_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            dly_p2  <= 1'b0;
        end else begin
            // stage p0 -> p1 -> p2
            meta_p0 <= async_in;
            sync_p1 <= meta_p0;
            dly_p2  <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~dly_p2;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver. BCLK is oversampled in the system clock domain; data and
// word select are sampled on each synchronised BCLK rising edge and
// assembled MSB-first into left/right samples, presented through a
// valid/ready register with a sticky overrun flag.
// Ports:
//   clk, rst_n           : system clock (>= 4x BCLK), async active-low reset
//   i2s_bclk/ws/din      : asynchronous I2S serial inputs (ws 0 = left)
//   out_left, out_right  : last complete frame
//   out_valid, out_ready : frame handshake
//   overrun              : sticky, a pending frame was overwritten
//   locked               : aligned to frame boundaries
module i2s_rx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i2s_bclk,
    input  logic                i2s_ws,
    input  logic                i2s_din,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic                locked
);

    localparam int CNT_W  = $clog2(SAMPLE_W + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(SAMPLE_W);
    localparam logic [IDLE_W-1:0]   IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [SAMPLE_W-1:0] SLOT_MSB = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Write one bit into the position selected by a one-hot mask.
    function automatic logic [SAMPLE_W-1:0] put_bit(
        input logic [SAMPLE_W-1:0] vec,
        input logic [SAMPLE_W-1:0] mask,
        input logic                d
    );
        return d ? (vec | mask) : (vec & ~mask);
    endfunction

    logic bclk_sync, bclk_rise;
    logic ws_sync, ws_rise;
    logic din_sync, din_rise;

    sync_edge u_bclk (.clk(clk), .rst_n(rst_n), .async_in(i2s_bclk), .level(bclk_sync), .rise(bclk_rise));
    sync_edge u_ws   (.clk(clk), .rst_n(rst_n), .async_in(i2s_ws),   .level(ws_sync),   .rise(ws_rise));
    sync_edge u_din  (.clk(clk), .rst_n(rst_n), .async_in(i2s_din),  .level(din_sync),  .rise(din_rise));

    // Only the bclk edge strobe is needed; ws/din edges and the bclk level are spare.
    logic unused_sync;
    assign unused_sync = ws_rise | din_rise | bclk_sync;

    rx_state_e             state, state_nxt;
    logic                  ws_prev;
    logic [CNT_W-1:0]      bit_cnt;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [SAMPLE_W-1:0]   shift_l, shift_r;
    logic                  xfer_p1;

    logic ws_chg, timeout;
    logic capture_l, capture_r, frame_end, cnt_clr, shift_clr;
    logic [SAMPLE_W-1:0] bit_mask;

    assign ws_chg   = bclk_rise & (ws_sync != ws_prev);
    assign timeout  = (idle_cnt == IDLE_MAX);
    // Mask shifts out to zero once bit_cnt saturates, dropping extra LSBs.
    assign bit_mask = SLOT_MSB >> bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = SYNC;
        end else begin
            case (state)
                SYNC:    if (ws_chg && !ws_sync) state_nxt = LEFT;
                LEFT:    if (ws_chg)             state_nxt = RIGHT;
                RIGHT:   if (ws_chg)             state_nxt = LEFT;
                default:                         state_nxt = SYNC;
            endcase
        end
    end

    always_comb begin
        capture_l = 1'b0;
        capture_r = 1'b0;
        frame_end = 1'b0;
        cnt_clr   = timeout;
        shift_clr = (state == SYNC) | xfer_p1;
        if (!timeout) begin
            case (state)
                SYNC: cnt_clr = ws_chg & ~ws_sync;
                LEFT: begin
                    capture_l = bclk_rise;
                    cnt_clr   = ws_chg;
                end
                RIGHT: begin
                    capture_r = bclk_rise;
                    frame_end = ws_chg;
                    cnt_clr   = ws_chg;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    // Sampling stage: runs on bclk_rise, tracks idle time and lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_prev  <= 1'b0;
            bit_cnt  <= '0;
            idle_cnt <= '0;
            shift_l  <= '0;
            shift_r  <= '0;
            xfer_p1  <= 1'b0;
            locked   <= 1'b0;
        end else begin
            if (bclk_rise) ws_prev <= ws_sync;

            if (bclk_rise)     idle_cnt <= '0;
            else if (!timeout) idle_cnt <= idle_cnt + 1'b1;

            if (cnt_clr)
                bit_cnt <= '0;
            else if ((capture_l || capture_r) && bit_cnt != CNT_MAX)
                bit_cnt <= bit_cnt + 1'b1;

            if (shift_clr)      shift_l <= '0;
            else if (capture_l) shift_l <= put_bit(shift_l, bit_mask, din_sync);

            if (shift_clr)      shift_r <= '0;
            else if (capture_r) shift_r <= put_bit(shift_r, bit_mask, din_sync);

            xfer_p1 <= frame_end;

            if (timeout)        locked <= 1'b0;
            else if (frame_end) locked <= 1'b1;
        end
    end

    // Presentation stage: one clock after the frame-closing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_left  <= '0;
            out_right <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (xfer_p1) begin
            out_left  <= shift_l;
            out_right <= shift_r;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
